// File: rtl/mag_sample_scheduler_if.sv
// ----------------------------------------------------------------------------
// mag_sample_scheduler_if
// Bundles the three handshakes of the magnetometer sample scheduler:
//   cmd_*   : command channel to the byte-level I2C engine (one outstanding)
//   rsp_*   : one-cycle response per accepted command (read byte / NACK flag)
//   frame_* : 80-bit sample frame towards the flight-data memory writer
// Modports:
//   master : the scheduler (drives commands and frames)
//   slave  : the I2C engine plus frame consumer (drives ready/response)
// ----------------------------------------------------------------------------
interface mag_sample_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_nack;
  logic        frame_valid;
  logic        frame_ready;
  logic [79:0] frame;
  logic        frame_overrun;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_nack,
    output frame_valid, frame, frame_overrun,
    input  frame_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_nack,
    input  frame_valid, frame, frame_overrun,
    output frame_ready
  );
endinterface

// File: rtl/mag_sample_scheduler.sv
// ----------------------------------------------------------------------------
// mag_sample_scheduler
// Sequences the magnetometer I2C link: one-time register initialisation, then
// periodic 6-byte burst reads packed into {b0..b5, timestamp, TAG} frames.
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   enable     permits new transactions (a running sequence always completes)
//   timestamp  mission time, latched when a read burst's first START is taken
//   bus        command / response / frame handshakes (master side)
//   init_done  initialisation finished
//   fault      sticky: too many consecutive NACKs, FSM parked until reset
//   busy       a transaction (or its backoff / emit) is in progress
// ----------------------------------------------------------------------------
module mag_sample_scheduler #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h1E,
  parameter logic [7:0]  CRA_VAL        = 8'h0C,
  parameter logic [7:0]  CRB_VAL        = 8'h00,
  parameter logic [7:0]  MODE_VAL       = 8'h00,
  parameter logic [7:0]  DATA_REG       = 8'h03,
  parameter logic [7:0]  TAG            = 8'h4D,
  parameter int unsigned PERIOD_CYCLES  = 100000,
  parameter int unsigned BACKOFF_CYCLES = 1000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] timestamp,
  mag_sample_scheduler_if.master bus,
  output logic        init_done,
  output logic        fault,
  output logic        busy
);

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_RACK  = 3'd2;
  localparam logic [2:0] OP_RNACK = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;

  localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
  localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [BO_W-1:0]  BO_LAST  = BO_W'(BACKOFF_CYCLES - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE_INIT, S_INIT, S_IDLE, S_READ, S_NSTOP, S_BACKOFF, S_EMIT, S_HALT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_step, w_step_nxt;
  logic             r_wait, w_wait_nxt;       // command accepted, awaiting response
  logic             r_is_read, w_is_read_nxt; // which sequence a retry restarts
  logic [RT_W-1:0]  r_retry, w_retry_nxt;
  logic [BO_W-1:0]  r_bo, w_bo_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             r_fault, w_fault_nxt;

  logic [PER_W-1:0] r_per;
  logic             r_tick;
  logic             r_frame_valid;
  logic [79:0]      r_frame;
  logic             r_overrun;
  logic [47:0]      r_bytes;
  logic [23:0]      r_ts;

  logic [10:0]      w_cmd;
  logic             w_cmd_valid;
  logic [2:0]       w_cmd_op;
  logic [7:0]       w_cmd_data;
  logic             w_first_start;
  logic             w_cap_byte;
  logic             w_emit;
  logic [RT_W-1:0]  w_retry_inc;
  logic [3:0]       w_last_step;

  // Command table: {op, data} for a step of the init or read sequence.
  function automatic logic [10:0] f_cmd(input logic is_read, input logic [3:0] step);
    logic [10:0] c;
    if (!is_read) begin
      unique case (step)
        4'd0:    c = {OP_START, 8'h00};
        4'd1:    c = {OP_WRITE, SLAVE_ADDR, 1'b0};
        4'd2:    c = {OP_WRITE, 8'h00};
        4'd3:    c = {OP_WRITE, CRA_VAL};
        4'd4:    c = {OP_WRITE, CRB_VAL};
        4'd5:    c = {OP_WRITE, MODE_VAL};
        default: c = {OP_STOP, 8'h00};
      endcase
    end else begin
      unique case (step)
        4'd0:    c = {OP_START, 8'h00};
        4'd1:    c = {OP_WRITE, SLAVE_ADDR, 1'b0};
        4'd2:    c = {OP_WRITE, DATA_REG};
        4'd3:    c = {OP_START, 8'h00};
        4'd4:    c = {OP_WRITE, SLAVE_ADDR, 1'b1};
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                 c = {OP_RACK, 8'h00};
        4'd10:   c = {OP_RNACK, 8'h00};
        default: c = {OP_STOP, 8'h00};
      endcase
    end
    return c;
  endfunction

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE_INIT;
      r_step      <= '0;
      r_wait      <= 1'b0;
      r_is_read   <= 1'b0;
      r_retry     <= '0;
      r_bo        <= '0;
      r_init_done <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_wait      <= w_wait_nxt;
      r_is_read   <= w_is_read_nxt;
      r_retry     <= w_retry_nxt;
      r_bo        <= w_bo_nxt;
      r_init_done <= w_init_done_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  // Next state, command outputs and datapath strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_wait_nxt      = r_wait;
    w_is_read_nxt   = r_is_read;
    w_retry_nxt     = r_retry;
    w_bo_nxt        = r_bo;
    w_init_done_nxt = r_init_done;
    w_fault_nxt     = r_fault;
    w_cmd           = f_cmd(r_is_read, r_step);
    w_cmd_valid     = 1'b0;
    w_cmd_op        = 3'd0;
    w_cmd_data      = 8'h00;
    w_first_start   = 1'b0;
    w_cap_byte      = 1'b0;
    w_emit          = 1'b0;
    w_retry_inc     = r_retry + 1'b1;
    w_last_step     = r_is_read ? 4'd11 : 4'd6;

    unique case (r_state)
      S_IDLE_INIT: begin
        if (enable) begin
          w_state_nxt   = S_INIT;
          w_step_nxt    = 4'd0;
          w_wait_nxt    = 1'b0;
          w_is_read_nxt = 1'b0;
        end
      end

      S_IDLE: begin
        if (r_tick && enable && !r_fault) begin
          w_state_nxt   = S_READ;
          w_step_nxt    = 4'd0;
          w_wait_nxt    = 1'b0;
          w_is_read_nxt = 1'b1;
        end
      end

      S_INIT, S_READ: begin
        if (!r_wait) begin
          w_cmd_valid = 1'b1;
          w_cmd_op    = w_cmd[10:8];
          w_cmd_data  = w_cmd[7:0];
          if (bus.cmd_ready) begin
            w_wait_nxt = 1'b1;
            if (r_is_read && r_step == 4'd0) w_first_start = 1'b1;
          end
        end else if (bus.rsp_valid) begin
          w_wait_nxt = 1'b0;
          if (r_is_read && r_step >= 4'd5 && r_step <= 4'd10) w_cap_byte = 1'b1;
          if (w_cmd[10:8] == OP_WRITE && bus.rsp_nack) begin
            w_state_nxt = S_NSTOP;
          end else if (r_step == w_last_step) begin
            w_retry_nxt = '0;
            if (r_is_read) begin
              w_state_nxt = S_EMIT;
            end else begin
              w_init_done_nxt = 1'b1;
              w_state_nxt     = S_IDLE;
            end
          end else begin
            w_step_nxt = r_step + 4'd1;
          end
        end
      end

      // Release the bus after a NACK, then either give up or back off.
      S_NSTOP: begin
        if (!r_wait) begin
          w_cmd_valid = 1'b1;
          w_cmd_op    = OP_STOP;
          if (bus.cmd_ready) w_wait_nxt = 1'b1;
        end else if (bus.rsp_valid) begin
          w_wait_nxt  = 1'b0;
          w_retry_nxt = w_retry_inc;
          if (w_retry_inc == RT_MAX) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_bo_nxt    = '0;
            w_state_nxt = S_BACKOFF;
          end
        end
      end

      // Retries restart the interrupted sequence even if enable has dropped.
      S_BACKOFF: begin
        if (r_bo == BO_LAST) begin
          w_state_nxt = r_is_read ? S_READ : S_INIT;
          w_step_nxt  = 4'd0;
          w_wait_nxt  = 1'b0;
        end else begin
          w_bo_nxt = r_bo + 1'b1;
        end
      end

      S_EMIT: begin
        w_emit      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      S_HALT: ;

      default: w_state_nxt = S_IDLE_INIT;
    endcase
  end

  // Period counter, tick flag and frame output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_per         <= '0;
      r_tick        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame       <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_first_start) r_tick <= 1'b0;
      // A wrap in the same cycle as the START wins: that tick is a new one.
      if (r_init_done) begin
        if (r_per == PER_LAST) begin
          r_per  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_per <= r_per + 1'b1;
        end
      end
      if (r_frame_valid && bus.frame_ready) r_frame_valid <= 1'b0;
      // An untaken frame has priority; the fresh sample is dropped.
      if (w_emit) begin
        if (!r_frame_valid) begin
          r_frame       <= {r_bytes, r_ts, TAG};
          r_frame_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  // Sample capture: bytes shift in so b0 ends up in the top byte.
  always_ff @(posedge clk) begin
    if (w_first_start) r_ts <= timestamp;
    if (w_cap_byte)    r_bytes <= {r_bytes[39:0], bus.rsp_data};
  end

  assign bus.cmd_valid     = w_cmd_valid;
  assign bus.cmd_op        = w_cmd_op;
  assign bus.cmd_data      = w_cmd_data;
  assign bus.frame_valid   = r_frame_valid;
  assign bus.frame         = r_frame;
  assign bus.frame_overrun = r_overrun;
  assign init_done         = r_init_done;
  assign fault             = r_fault;
  assign busy              = !(r_state inside {S_IDLE_INIT, S_IDLE, S_HALT});

endmodule
